// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder sequencing one full_adder cell, LSB first
// Optional feature macro: SERIAL_ADD_OVF_EN (signed overflow flag; ovf tied low when undefined)
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               request, sampled only in IDLE
//   op_a, op_b, cin     operands and carry-in, captured on accepted start
//   busy                high for the WIDTH cycles of RUN
//   done                one-cycle pulse when result/cout/ovf are updated
//   result, cout, ovf   sum, carry out of MSB, signed overflow; held until next done

module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, nxt;
    logic [WIDTH-1:0] sa, sb, acc_n;
    logic [WIDTH-2:0] acc;
    logic [CW-1:0]    cnt;
    logic             cq, sum, carry, last;
    full_adder u_fa (.a(sa[0]), .b(sb[0]), .c(cq), .sum(sum), .carry(carry));
    assign last  = cnt == CW'(WIDTH - 1);
    // Only the upper WIDTH-1 sum bits need storing; the newest bit joins on the fly.
    assign acc_n = {sum, acc};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? RUN : IDLE;
            RUN:     nxt = last ? DONE : RUN;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        busy = state == RUN;
        done = state == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            acc    <= '0;
            cq     <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else if (state == IDLE && start) begin
            sa  <= op_a;
            sb  <= op_b;
            cq  <= cin;
            cnt <= '0;
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            acc <= acc_n[WIDTH-1:1];
            cq  <= carry;
            cnt <= cnt + 1'b1;
            if (last) begin
                result <= acc_n;
                cout   <= carry;
            end
        end
    end
`ifdef SERIAL_ADD_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    ovf <= 1'b0;
        else if (state == RUN && last) ovf <= cq ^ carry;
    end
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed self-checking bench for serial_adder_ctrl (WIDTH=8)
module tb_serial_adder_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
    logic [7:0] op_a = '0, op_b = '0;
    logic       busy, done, cout, ovf;
    logic [7:0] result;
    int         vecs = 0, errs = 0;
`ifdef SERIAL_ADD_OVF_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
        .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Drives one transaction and observes 20 cycles after the accepting edge.
    task automatic do_add(input logic [7:0] a, b, input logic ci, input bit intrude,
                          output int bcyc, dcyc, ndone, output logic [7:0] r,
                          output logic co, ov, output bit stable);
        logic [7:0] r0;
        r0 = result; bcyc = 0; dcyc = 0; ndone = 0; r = '0; co = 1'b0; ov = 1'b0; stable = 1'b1;
        @(negedge clk);
        op_a = a; op_b = b; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op_a = ~a; op_b = ~b; cin = ~ci;
        for (int k = 1; k <= 20; k++) begin
            if (busy) begin
                bcyc++;
                if (result !== r0) stable = 1'b0;
            end
            if (done) begin
                ndone++;
                if (dcyc == 0) begin dcyc = k; r = result; co = cout; ov = ovf; end
            end
            start = intrude && (k == 3 || k == 9);
            if (intrude) begin op_a = 8'h01; op_b = 8'h01; end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; op_a = 8'hFF; op_b = 8'hFF; cin = 1'b1;
        repeat (3) @(negedge clk);
        vecs++; if (busy !== 1'b0)   begin errs++; $display("FAIL rst_busy: got %b expected 0", busy); end
        vecs++; if (done !== 1'b0)   begin errs++; $display("FAIL rst_done: got %b expected 0", done); end
        vecs++; if (result !== 8'h0) begin errs++; $display("FAIL rst_result: got %h expected 00", result); end
        vecs++; if (cout !== 1'b0)   begin errs++; $display("FAIL rst_cout: got %b expected 0", cout); end
        vecs++; if (ovf !== 1'b0)    begin errs++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vecs++; if (busy !== 1'b0)   begin errs++; $display("FAIL rst_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic;
        int bc, dc, nd; logic [7:0] r; logic co, ov; bit st;
        do_add(8'h05, 8'h03, 1'b0, 1'b0, bc, dc, nd, r, co, ov, st);
        vecs++; if (bc !== 8)     begin errs++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
        vecs++; if (dc !== 9)     begin errs++; $display("FAIL basic_done_cycle: got %0d expected 9", dc); end
        vecs++; if (nd !== 1)     begin errs++; $display("FAIL basic_done_count: got %0d expected 1", nd); end
        vecs++; if (r !== 8'h08)  begin errs++; $display("FAIL basic_result: got %h expected 08", r); end
        vecs++; if (co !== 1'b0)  begin errs++; $display("FAIL basic_cout: got %b expected 0", co); end
        vecs++; if (ov !== 1'b0)  begin errs++; $display("FAIL basic_ovf: got %b expected 0", ov); end
        vecs++; if (st !== 1'b1)  begin errs++; $display("FAIL basic_result_stable: got %b expected 1", st); end
        vecs++; if (result !== 8'h08) begin errs++; $display("FAIL basic_result_held: got %h expected 08", result); end
    endtask

    task automatic test_carry;
        int bc, dc, nd; logic [7:0] r; logic co, ov; bit st;
        do_add(8'hFF, 8'h01, 1'b0, 1'b0, bc, dc, nd, r, co, ov, st);
        vecs++; if (r !== 8'h00) begin errs++; $display("FAIL carry1_result: got %h expected 00", r); end
        vecs++; if (co !== 1'b1) begin errs++; $display("FAIL carry1_cout: got %b expected 1", co); end
        vecs++; if (ov !== 1'b0) begin errs++; $display("FAIL carry1_ovf: got %b expected 0", ov); end
        vecs++; if (st !== 1'b1) begin errs++; $display("FAIL carry1_stable: got %b expected 1", st); end
        do_add(8'hFF, 8'hFF, 1'b1, 1'b0, bc, dc, nd, r, co, ov, st);
        vecs++; if (r !== 8'hFF) begin errs++; $display("FAIL carry2_result: got %h expected ff", r); end
        vecs++; if (co !== 1'b1) begin errs++; $display("FAIL carry2_cout: got %b expected 1", co); end
        vecs++; if (ov !== 1'b0) begin errs++; $display("FAIL carry2_ovf: got %b expected 0", ov); end
        do_add(8'h00, 8'h00, 1'b1, 1'b0, bc, dc, nd, r, co, ov, st);
        vecs++; if (r !== 8'h01) begin errs++; $display("FAIL cin_only_result: got %h expected 01", r); end
        vecs++; if (co !== 1'b0) begin errs++; $display("FAIL cin_only_cout: got %b expected 0", co); end
    endtask

    task automatic test_ovf;
        int bc, dc, nd; logic [7:0] r; logic co, ov; bit st;
        do_add(8'h7F, 8'h01, 1'b0, 1'b0, bc, dc, nd, r, co, ov, st);
        vecs++; if (r !== 8'h80)   begin errs++; $display("FAIL ovf_result: got %h expected 80", r); end
        vecs++; if (co !== 1'b0)   begin errs++; $display("FAIL ovf_cout: got %b expected 0", co); end
        vecs++; if (ov !== OVF_EN) begin errs++; $display("FAIL ovf_flag: got %b expected %b", ov, OVF_EN); end
        do_add(8'h80, 8'h80, 1'b0, 1'b0, bc, dc, nd, r, co, ov, st);
        vecs++; if (r !== 8'h00)   begin errs++; $display("FAIL ovf_neg_result: got %h expected 00", r); end
        vecs++; if (co !== 1'b1)   begin errs++; $display("FAIL ovf_neg_cout: got %b expected 1", co); end
        vecs++; if (ov !== OVF_EN) begin errs++; $display("FAIL ovf_neg_flag: got %b expected %b", ov, OVF_EN); end
    endtask

    task automatic test_ignore_start;
        int bc, dc, nd; logic [7:0] r; logic co, ov; bit st;
        do_add(8'hA5, 8'h5A, 1'b0, 1'b1, bc, dc, nd, r, co, ov, st);
        vecs++; if (r !== 8'hFF) begin errs++; $display("FAIL ignore_result: got %h expected ff", r); end
        vecs++; if (co !== 1'b0) begin errs++; $display("FAIL ignore_cout: got %b expected 0", co); end
        vecs++; if (nd !== 1)    begin errs++; $display("FAIL ignore_done_count: got %0d expected 1", nd); end
        vecs++; if (bc !== 8)    begin errs++; $display("FAIL ignore_busy_cycles: got %0d expected 8", bc); end
        vecs++; if (dc !== 9)    begin errs++; $display("FAIL ignore_done_cycle: got %0d expected 9", dc); end
    endtask

    task automatic test_reset_mid_run;
        int bc, dc, nd, nd_rst; logic [7:0] r; logic co, ov; bit st;
        @(negedge clk);
        op_a = 8'h33; op_b = 8'h44; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        vecs++; if (busy !== 1'b0)   begin errs++; $display("FAIL mid_busy_async: got %b expected 0", busy); end
        vecs++; if (result !== 8'h0) begin errs++; $display("FAIL mid_result_cleared: got %h expected 00", result); end
        vecs++; if (cout !== 1'b0)   begin errs++; $display("FAIL mid_cout_cleared: got %b expected 0", cout); end
        nd_rst = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) nd_rst++;
        end
        rst_n = 1'b1;
        vecs++; if (nd_rst !== 0)    begin errs++; $display("FAIL mid_no_done: got %0d expected 0", nd_rst); end
        do_add(8'h10, 8'h20, 1'b0, 1'b0, bc, dc, nd, r, co, ov, st);
        vecs++; if (r !== 8'h30)     begin errs++; $display("FAIL mid_fresh_result: got %h expected 30", r); end
        vecs++; if (co !== 1'b0)     begin errs++; $display("FAIL mid_fresh_cout: got %b expected 0", co); end
        vecs++; if (dc !== 9)        begin errs++; $display("FAIL mid_fresh_done_cycle: got %0d expected 9", dc); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_ovf;
        test_ignore_start;
        test_reset_mid_run;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
